// File: rtl/onchip_memory_dp.sv
// True-dual-port on-chip RAM with two Avalon-MM slave ports, per-byte write enables
// and a fixed-latency readdatavalid pipeline (1 or 2 cycles).

module onchip_memory_dp_rdpipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] readdata,
  output logic                  readdatavalid
);
  logic [STAGES:0]                 vld_pipe;
  logic [STAGES:0][DATA_WIDTH-1:0] dat_pipe;

  // Data registers only load when a read moves through, so readdata holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (en) begin
      vld_pipe[0] <= rd;
      if (rd) dat_pipe[0] <= word;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  assign readdata      = dat_pipe[STAGES];
  // Gating with en makes a stalled completion pulse once, when the stall releases.
  assign readdatavalid = vld_pipe[STAGES] & en;
endmodule

module onchip_memory_dp #(
  parameter int    DATA_WIDTH = 32,
  parameter int    ADDR_WIDTH = 16,
  parameter int    DEPTH      = 40000,
  parameter int    OUTPUT_REG = 0,
  parameter string INIT_FILE  = "onchip_memory_dp.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);
  localparam int NB = DATA_WIDTH/8;
  localparam int NP = 2;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];

  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic                          en;
  logic [NP-1:0][ADDR_WIDTH-1:0] addr;
  logic [NP-1:0][NB-1:0]         be;
  logic [NP-1:0][DATA_WIDTH-1:0] wdata, rword, rdata;
  logic [NP-1:0]                 cs, rd_req, wr_req, in_range, rd_acc, wr_acc, rvalid;

  // Index 0 is s1, index 1 is s2.
  assign en     = clken & ~reset_req;
  assign addr   = {s2_address, s1_address};
  assign be     = {s2_byteenable, s1_byteenable};
  assign wdata  = {s2_writedata, s1_writedata};
  assign cs     = {s2_chipselect, s1_chipselect};
  assign rd_req = {s2_read, s1_read};
  assign wr_req = {s2_write, s1_write};

  for (genvar p = 0; p < NP; p++) begin : g_port
    assign in_range[p] = {1'b0, addr[p]} < DEPTH_W;
    assign wr_acc[p]   = cs[p] & wr_req[p] & en & in_range[p];
    assign rd_acc[p]   = cs[p] & rd_req[p] & ~wr_req[p] & en;
    assign rword[p]    = in_range[p] ? mem[addr[p]] : '0;
  end

  // s2 lanes are applied first so s1 overrides on a same-address, same-lane collision.
  always_ff @(posedge clk) begin
    for (int p = NP-1; p >= 0; p--)
      for (int b = 0; b < NB; b++)
        if (wr_acc[p] && be[p][b]) mem[addr[p]][b*8 +: 8] <= wdata[p][b*8 +: 8];
  end

  onchip_memory_dp_rdpipe #(
    .DATA_WIDTH(DATA_WIDTH),
    .STAGES    (OUTPUT_REG)
  ) u_rdpipe [NP-1:0] (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .rd           (rd_acc),
    .word         (rword),
    .readdata     (rdata),
    .readdatavalid(rvalid)
  );

  assign s1_readdata      = rdata[0];
  assign s2_readdata      = rdata[1];
  assign s1_readdatavalid = rvalid[0];
  assign s2_readdatavalid = rvalid[1];
endmodule

// File: tb/tb_onchip_memory_dp.sv
// Directed bench: one instance per read latency, both driven by the same stimulus.
module tb_onchip_memory_dp;
  logic        clk, reset, clken, reset_req;
  logic [15:0] s1_address, s2_address;
  logic        s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [3:0]  s1_byteenable, s2_byteenable;
  logic [31:0] s1_writedata, s2_writedata;
  logic [31:0] q0_s1_d, q0_s2_d, q1_s1_d, q1_s2_d;
  logic        q0_s1_v, q0_s2_v, q1_s1_v, q1_s2_v;
  int checks = 0, failures = 0;
  logic [31:0] sd [4];

  onchip_memory_dp #(.OUTPUT_REG(0), .INIT_FILE("")) dut0 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(q0_s1_d), .s1_readdatavalid(q0_s1_v),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(q0_s2_d), .s2_readdatavalid(q0_s2_v));

  onchip_memory_dp #(.OUTPUT_REG(1), .INIT_FILE("")) dut1 (
    .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(q1_s1_d), .s1_readdatavalid(q1_s1_v),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
    .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
    .s2_readdata(q1_s2_d), .s2_readdatavalid(q1_s2_v));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_v(input int d, input int p);
    logic v;
    if (d == 0) v = (p == 1) ? q0_s1_v : q0_s2_v;
    else        v = (p == 1) ? q1_s1_v : q1_s2_v;
    return {31'b0, v};
  endfunction

  function automatic logic [31:0] get_d(input int d, input int p);
    if (d == 0) return (p == 1) ? q0_s1_d : q0_s2_d;
    return (p == 1) ? q1_s1_d : q1_s2_d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s2_chipselect = 0; s2_read = 0; s2_write = 0;
  endtask

  task automatic drive_rd(input int p, input logic [15:0] a);
    if (p == 1) begin s1_chipselect = 1; s1_read = 1; s1_address = a; end
    else        begin s2_chipselect = 1; s2_read = 1; s2_address = a; end
  endtask

  task automatic drive_wr(input int p, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    if (p == 1) begin
      s1_chipselect = 1; s1_write = 1; s1_address = a; s1_writedata = d; s1_byteenable = be;
    end else begin
      s2_chipselect = 1; s2_write = 1; s2_address = a; s2_writedata = d; s2_byteenable = be;
    end
  endtask

  task automatic wr(input int p, input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
    drive_wr(p, a, d, be);
    tick();
    idle();
  endtask

  // Single read: latency-1 instance answers after the issue edge, latency-2 one edge later.
  task automatic check_read(input int p, input logic [15:0] a, input logic [31:0] exp,
                            input string tag);
    drive_rd(p, a);
    tick();
    idle();
    #1;
    chk({tag, ":l1_v"}, get_v(0, p), 32'd1);
    chk({tag, ":l1_d"}, get_d(0, p), exp);
    chk({tag, ":l2_v_early"}, get_v(1, p), 32'd0);
    tick();
    chk({tag, ":l1_v_once"}, get_v(0, p), 32'd0);
    chk({tag, ":l2_v"}, get_v(1, p), 32'd1);
    chk({tag, ":l2_d"}, get_d(1, p), exp);
    tick();
    chk({tag, ":l2_v_once"}, get_v(1, p), 32'd0);
  endtask

  // Stall scenario inputs for edge k: clken low on edges 1..3, read 1 held until accepted.
  task automatic stall_drive(input int k);
    clken = !(k >= 1 && k <= 3);
    idle();
    if (k == 0)      drive_rd(1, 16'd0);
    else if (k <= 4) drive_rd(1, 16'd1);
    else if (k <= 6) drive_rd(1, 16'(k - 3));
  endtask

  initial begin
    reset = 1; clken = 1; reset_req = 0;
    s1_address = 0; s2_address = 0; s1_byteenable = 0; s2_byteenable = 0;
    s1_writedata = 0; s2_writedata = 0;
    idle();
    tick(); tick();
    chk("rst_l1_s1_d", q0_s1_d, 32'd0);  chk("rst_l1_s1_v", {31'b0, q0_s1_v}, 32'd0);
    chk("rst_l1_s2_d", q0_s2_d, 32'd0);  chk("rst_l1_s2_v", {31'b0, q0_s2_v}, 32'd0);
    chk("rst_l2_s1_d", q1_s1_d, 32'd0);  chk("rst_l2_s1_v", {31'b0, q1_s1_v}, 32'd0);
    chk("rst_l2_s2_d", q1_s2_d, 32'd0);  chk("rst_l2_s2_v", {31'b0, q1_s2_v}, 32'd0);
    reset = 0;
    tick();

    wr(1, 16'd5, 32'hDEADBEEF, 4'hF);
    check_read(2, 16'd5, 32'hDEADBEEF, "basic");

    wr(1, 16'd7, 32'h11223344, 4'hF);
    wr(1, 16'd7, 32'hAABBCCDD, 4'h5);
    check_read(2, 16'd7, 32'h11BB33DD, "bytelane");
    wr(2, 16'd7, 32'h99999999, 4'h0);
    check_read(1, 16'd7, 32'h11BB33DD, "be_zero");

    drive_wr(1, 16'd9, 32'h000000FF, 4'h1);
    drive_wr(2, 16'd9, 32'hFFFFFF00, 4'hF);
    tick(); idle();
    check_read(2, 16'd9, 32'hFFFFFFFF, "coll_ww");

    wr(1, 16'd3, 32'h33333333, 4'hF);
    drive_wr(1, 16'd3, 32'h44444444, 4'hF);
    drive_rd(2, 16'd3);
    tick(); idle();
    chk("coll_rw_l1_v", get_v(0, 2), 32'd1);
    chk("coll_rw_l1_d", get_d(0, 2), 32'h33333333);
    tick();
    chk("coll_rw_l2_v", get_v(1, 2), 32'd1);
    chk("coll_rw_l2_d", get_d(1, 2), 32'h33333333);
    tick();
    check_read(2, 16'd3, 32'h44444444, "coll_new");

    // read and write together: write wins, nothing is flagged
    drive_wr(1, 16'd3, 32'h66666666, 4'hF);
    s1_read = 1;
    tick(); idle();
    chk("rw_l1_noread", get_v(0, 1), 32'd0);
    tick();
    chk("rw_l2_noread", get_v(1, 1), 32'd0);
    check_read(1, 16'd3, 32'h66666666, "rw_wrote");

    wr(1, 16'd39999, 32'h5A5A5A5A, 4'hF);
    wr(1, 16'd40000, 32'h12345678, 4'hF);
    check_read(2, 16'd40000, 32'h00000000, "oor_rd");
    check_read(2, 16'd39999, 32'h5A5A5A5A, "oor_keep");

    for (int i = 0; i < 4; i++) begin
      sd[i] = 32'hA5A50000 + 32'(i);
      wr(1, 16'(i), sd[i], 4'hF);
    end
    stall_drive(0);
    tick();
    for (int c = 0; c < 9; c++) begin
      stall_drive(c + 1);
      #1;
      chk($sformatf("stall_l1_v_c%0d", c), get_v(0, 1), {31'b0, (c >= 3 && c <= 6)});
      if (c >= 3 && c <= 6) chk($sformatf("stall_l1_d_c%0d", c), get_d(0, 1), sd[c-3]);
      chk($sformatf("stall_l2_v_c%0d", c), get_v(1, 1), {31'b0, (c >= 4 && c <= 7)});
      if (c >= 4 && c <= 7) chk($sformatf("stall_l2_d_c%0d", c), get_d(1, 1), sd[c-4]);
      tick();
    end
    clken = 1; idle();

    // reset lands one cycle after the read was issued
    drive_rd(1, 16'd2);
    tick(); idle();
    reset = 1;
    tick();
    reset = 0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rst_mid_l2_v_c%0d", c), get_v(1, 1), 32'd0);
      chk($sformatf("rst_mid_l2_d_c%0d", c), get_d(1, 1), 32'd0);
      chk($sformatf("rst_mid_l1_d_c%0d", c), get_d(0, 1), 32'd0);
      tick();
    end
    check_read(1, 16'd2, sd[2], "rst_mem");
    check_read(2, 16'd5, 32'hDEADBEEF, "rst_mem5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/onchip_memory_dp.md
# onchip_memory_dp

Parametrised true-dual-port on-chip RAM with two independent Avalon-MM slave ports (s1, s2), per-byte write enables, a selectable output register stage, and `readdatavalid` signalling with a fixed, known latency. It is the successor to the single-port Qsys on-chip memory: width, depth and read latency are generic, and a second port lets the HPS bridge and a fabric master share one buffer. Memory is inferred as block RAM; contents may be preloaded from `INIT_FILE`.

## Interface
- `DATA_WIDTH`, 32: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 16: word-address width.
- `DEPTH`, 40000: number of words; must satisfy DEPTH ≤ 2^ADDR_WIDTH.
- `OUTPUT_REG`, 0: 0 gives read latency 1; 1 gives read latency 2.
- `INIT_FILE`, "onchip_memory_dp.hex": initial contents; "" leaves contents undefined.
- `clk` input, 1 bit: single clock for both ports.
- `reset` input, 1 bit: synchronous, active-high.
- `clken` input, 1 bit: global clock enable.
- `reset_req` input, 1 bit: when high, stalls the block the same way `clken`=0 does.
- `s1_address`, `s2_address` input, ADDR_WIDTH bits: word address.
- `s1_chipselect`, `s2_chipselect` input, 1 bit: port select.
- `s1_read`, `s2_read` input, 1 bit: read request.
- `s1_write`, `s2_write` input, 1 bit: write request.
- `s1_byteenable`, `s2_byteenable` input, DATA_WIDTH/8 bits: byte lanes to write.
- `s1_writedata`, `s2_writedata` input, DATA_WIDTH bits: write data.
- `s1_readdata`, `s2_readdata` output, DATA_WIDTH bits: read data.
- `s1_readdatavalid`, `s2_readdatavalid` output, 1 bit: one-cycle qualifier for readdata.

## Operation
- `en = clken & ~reset_req`. When `en`=0, no request is accepted (requests are dropped, not queued), memory is not written, and all pipeline registers hold their values.
- Accepted write on port X: `chipselect & write & en`. Each byte lane i with `byteenable[i]`=1 is updated; the other lanes are unchanged. `byteenable`=0 writes nothing.
- Accepted read on port X: `chipselect & read & ~write & en`. If read and write are both high on a port, the write wins and no read is issued.
- Address ≥ DEPTH: a write is discarded; a read completes normally with readdata = 0.
- Both ports write the same address in the same cycle: lanes enabled on s1 take s1 data; lanes enabled only on s2 take s2 data.
- Read on one port and write on the other port to the same address in the same cycle: the read returns the old data. A same-port write followed by a read in the next cycle returns the new data.
- Each port has a valid pipeline of depth L = 1 + OUTPUT_REG. The stage-0 flag is set by an accepted read. Stages advance only when `en`=1.
- `sX_readdatavalid` = (last-stage valid) & `en`. Each accepted read is therefore flagged exactly once, even when a stall is in progress.
- `sX_readdata` holds its last value until the next read completes. It is not cleared on writes.
- `reset`: clears all valid flags and all readdata and output registers to 0. Memory contents are preserved. Reads in flight when reset is asserted are lost and never flagged.

## Timing
- Read accepted at edge t: data and `readdatavalid`=1 appear in the cycle after edge t+L-1 (L=1: the next cycle; L=2: two cycles later), assuming `en`=1 throughout.
- A stall of k cycles (`en`=0) at any point delays completion by exactly k cycles.
- Throughput is one read or write per port per cycle with no `waitrequest`. Back-to-back reads give back-to-back `readdatavalid`.
- A write takes effect at the accepting edge.
- Reset values: `s1_readdata` = `s2_readdata` = 0; `s1_readdatavalid` = `s2_readdatavalid` = 0. These values are visible in the cycle after the reset edge.
- All outputs are registered except the `& en` gating of `readdatavalid`.

## Test plan
- Defaults, OUTPUT_REG=0: write 0xDEADBEEF to address 5 via s1; read address 5 on s2 the next cycle. Required: `s2_readdatavalid` is high for exactly 1 cycle, one cycle after the read, with data 0xDEADBEEF.
- Byte lanes: write 0x11223344 to address 7 with byteenable=0xF, then write 0xAABBCCDD with byteenable=0x5. Required: a read of address 7 returns 0x11BB33DD.
- Collision: in the same cycle, s1 writes 0x000000FF to address 9 with be=0x1 and s2 writes 0xFFFFFF00 with be=0xF. Required: a read of address 9 returns 0xFFFFFFFF. Then, in one cycle, s1 writes address 3 while s2 reads address 3. Required: the s2 read returns the old value.
- OUTPUT_REG=1 with a stall: issue 4 back-to-back reads on s1 to addresses 0 to 3, drop `clken` for 3 cycles starting 1 cycle after the first read, then restore it. Required: 4 `readdatavalid` pulses in address order, the first one 2+3 cycles after issue, and no duplicated pulse.
- Out of range, DEPTH=40000: write to address 40000, then read addresses 40000 and 39999. Required: the first read returns 0 with a valid pulse; address 39999 is unchanged.
- Reset mid-read: assert `reset` the cycle after issuing a read with OUTPUT_REG=1. Required: no `readdatavalid` pulse appears, readdata = 0, and previously written memory data is still readable after reset.
